// File: rtl/switch_debounce.sv
// Input conditioning for 16 slide switches and a confirm button: two-flop
// synchronizers, a whole-bus switch debounce, and a debounced confirm press
// that snapshots the switch bus into a CPU-acknowledged latch.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switch_raw,
  input  logic        confirm_raw,
  input  logic        read_ack,
  output logic [15:0] switch_stable,
  output logic [15:0] switch_latched,
  output logic        confirm_pulse,
  output logic        confirm_pending,
  output logic        overrun
);

  localparam int              NUM_LANES = 17;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } cfm_state_e;

  // Synchronizers: lane 16 is the confirm button, lanes 15:0 the switches.
  logic [NUM_LANES-1:0] raw_bus, sync_meta, sync_bus;
  logic [15:0]          sw_sync;
  logic                 cfm_sync;

  assign raw_bus  = {confirm_raw, switch_raw};
  assign sw_sync  = sync_bus[15:0];
  assign cfm_sync = sync_bus[16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_bus  <= '0;
    end else begin
      sync_meta <= raw_bus;
      sync_bus  <= sync_meta;
    end
  end

  // Whole-bus debounce: any bit change restarts the window for every bit.
  logic [15:0]      cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand          <= '0;
      cnt           <= '0;
      switch_stable <= '0;
    end else if (sw_sync != cand) begin
      cand <= sw_sync;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      switch_stable <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Confirm button FSM
  cfm_state_e       state, state_nxt;
  logic [CNT_W-1:0] ccnt, ccnt_nxt;
  logic             press_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      ccnt  <= '0;
    end else begin
      state <= state_nxt;
      ccnt  <= ccnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ccnt_nxt  = ccnt;
    case (state)
      RELEASED: begin
        if (cfm_sync) begin
          state_nxt = PRESS_WAIT;
          ccnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!cfm_sync)            state_nxt = RELEASED;
        else if (ccnt == CNT_MAX) state_nxt = PRESSED;
        else                      ccnt_nxt  = ccnt + CNT_W'(1);
      end
      PRESSED: begin
        if (!cfm_sync) begin
          state_nxt = RELEASE_WAIT;
          ccnt_nxt  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (cfm_sync)             state_nxt = PRESSED;
        else if (ccnt == CNT_MAX) state_nxt = RELEASED;
        else                      ccnt_nxt  = ccnt + CNT_W'(1);
      end
      default: state_nxt = RELEASED;
    endcase
  end

  always_comb begin
    press_evt = (state == PRESS_WAIT) && cfm_sync && (ccnt == CNT_MAX);
  end

  // Press beats a coincident ack; the ack still consumes the old snapshot,
  // so overrun is not raised for it.
  logic ack_hit;
  assign ack_hit = read_ack && confirm_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      confirm_pulse   <= 1'b0;
      confirm_pending <= 1'b0;
      overrun         <= 1'b0;
      switch_latched  <= '0;
    end else begin
      confirm_pulse <= press_evt;
      if (press_evt) begin
        switch_latched  <= switch_stable;
        confirm_pending <= 1'b1;
        overrun         <= ack_hit ? 1'b0 : (overrun | confirm_pending);
      end else if (ack_hit) begin
        confirm_pending <= 1'b0;
        overrun         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a window-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_switch_debounce;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switch_raw;
  logic        confirm_raw;
  logic        read_ack;
  logic [15:0] switch_stable, switch_latched;
  logic        confirm_pulse, confirm_pending, overrun;

  switch_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .switch_raw     (switch_raw),
    .confirm_raw    (confirm_raw),
    .read_ack       (read_ack),
    .switch_stable  (switch_stable),
    .switch_latched (switch_latched),
    .confirm_pulse  (confirm_pulse),
    .confirm_pending(confirm_pending),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a value is accepted once the synchronized input (raw
  // delayed two edges) has been identical for D+1 consecutive edges.
  logic [16:0] hist [D+3];
  logic [15:0] m_stable, m_latched;
  logic        m_pulse, m_pend, m_ovr, m_lvl;
  logic        m_sw_eq, m_all1, m_all0, m_evt;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < D + 3; i++) hist[i] = '0;
        m_stable = '0; m_latched = '0;
        m_pulse = 0; m_pend = 0; m_ovr = 0; m_lvl = 0;
      end else begin
        for (int i = D + 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {confirm_raw, switch_raw};
        m_sw_eq = 1; m_all1 = 1; m_all0 = 1;
        for (int i = 2; i <= D + 2; i++) begin
          if (hist[i][15:0] != hist[2][15:0]) m_sw_eq = 0;
          if (hist[i][16]) m_all0 = 0; else m_all1 = 0;
        end
        m_evt   = m_all1 && !m_lvl;
        m_pulse = m_evt;
        if (m_evt) begin
          m_latched = m_stable;
          m_ovr     = (read_ack && m_pend) ? 1'b0 : (m_ovr | m_pend);
          m_pend    = 1;
        end else if (read_ack && m_pend) begin
          m_pend = 0;
          m_ovr  = 0;
        end
        if (m_sw_eq) m_stable = hist[2][15:0];
        if (m_all1) m_lvl = 1;
        if (m_all0) m_lvl = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      chk("stable",  32'(switch_stable),   32'(m_stable));
      chk("latched", 32'(switch_latched),  32'(m_latched));
      chk("pulse",   32'(confirm_pulse),   32'(m_pulse));
      chk("pending", 32'(confirm_pending), 32'(m_pend));
      chk("overrun", 32'(overrun),         32'(m_ovr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse;
    read_ack = 1'b1;
    cyc(1);
    read_ack = 1'b0;
  endtask

  task automatic press_with(input logic [15:0] sw);
    switch_raw  = sw;
    cyc(8);
    confirm_raw = 1'b1;
    cyc(8);
    confirm_raw = 1'b0;
    cyc(8);
  endtask

  initial begin
    rst = 1'b1; switch_raw = 16'hA5A5; confirm_raw = 1'b1; read_ack = 1'b0;

    // Reset with inputs active
    cyc(3);
    chk("rst_stable",  32'(switch_stable),   32'h0);
    chk("rst_latched", 32'(switch_latched),  32'h0);
    chk("rst_pulse",   32'(confirm_pulse),   32'h0);
    chk("rst_pending", 32'(confirm_pending), 32'h0);
    chk("rst_overrun", 32'(overrun),         32'h0);
    rst = 1'b0;
    cyc(6);
    chk("post_rst_stable_early", 32'(switch_stable), 32'h0);
    chk("post_rst_pulse_early",  32'(confirm_pulse), 32'h0);
    cyc(1);
    chk("post_rst_stable",  32'(switch_stable),   32'hA5A5);
    chk("post_rst_pulse",   32'(confirm_pulse),   32'h1);
    chk("post_rst_latched", 32'(switch_latched),  32'h0);
    chk("post_rst_pending", 32'(confirm_pending), 32'h1);
    cyc(1);
    chk("post_rst_pulse_once", 32'(confirm_pulse), 32'h0);
    confirm_raw = 1'b0;
    cyc(8);
    ack_pulse();
    chk("ack1_clear", 32'(confirm_pending), 32'h0);

    // Switch bounce then settle at 0001
    for (int i = 0; i < 10; i++) begin
      switch_raw = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      cyc(2);
    end
    chk("bounce_hold", 32'(switch_stable), 32'hA5A5);
    switch_raw = 16'h0001;
    cyc(6);
    chk("settle_early", 32'(switch_stable), 32'hA5A5);
    cyc(1);
    chk("settle", 32'(switch_stable), 32'h0001);

    // Clean press
    switch_raw = 16'h1234;
    cyc(8);
    confirm_raw = 1'b1;
    cyc(6);
    chk("clean_pulse_early", 32'(confirm_pulse), 32'h0);
    cyc(1);
    chk("clean_pulse",   32'(confirm_pulse),   32'h1);
    chk("clean_latched", 32'(switch_latched),  32'h1234);
    chk("clean_pending", 32'(confirm_pending), 32'h1);
    chk("clean_overrun", 32'(overrun),         32'h0);
    cyc(3);
    confirm_raw = 1'b0;
    cyc(8);
    ack_pulse();
    chk("clean_ack", 32'(confirm_pending), 32'h0);

    // Press bounce: never D+1 stable samples
    repeat (4) begin
      confirm_raw = 1'b1;
      cyc(3);
      confirm_raw = 1'b0;
      cyc(1);
    end
    cyc(10);
    chk("bounce_pending", 32'(confirm_pending), 32'h0);
    ack_pulse();
    chk("idle_ack", 32'(confirm_pending), 32'h0);

    // Overrun, then ack coincident with a third press
    press_with(16'h0011);
    press_with(16'h0022);
    chk("ovr_latched", 32'(switch_latched),  32'h0022);
    chk("ovr_flag",    32'(overrun),         32'h1);
    chk("ovr_pending", 32'(confirm_pending), 32'h1);
    switch_raw = 16'h0033;
    cyc(8);
    confirm_raw = 1'b1;
    cyc(6);
    ack_pulse();
    chk("sim_pulse",   32'(confirm_pulse),   32'h1);
    chk("sim_pending", 32'(confirm_pending), 32'h1);
    chk("sim_overrun", 32'(overrun),         32'h0);
    chk("sim_latched", 32'(switch_latched),  32'h0033);
    cyc(2);
    confirm_raw = 1'b0;
    cyc(8);

    // Reset in the middle of a press, button held through release
    confirm_raw = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    chk("midrst_pending", 32'(confirm_pending), 32'h0);
    chk("midrst_latched", 32'(switch_latched),  32'h0);
    rst = 1'b0;
    cyc(6);
    chk("midrst_pulse_early", 32'(confirm_pulse), 32'h0);
    cyc(1);
    chk("midrst_pulse",   32'(confirm_pulse),   32'h1);
    chk("midrst_latched", 32'(switch_latched),  32'h0);
    cyc(10);
    confirm_raw = 1'b0;
    cyc(8);
    chk("midrst_single", 32'(confirm_pending), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
